ast_mac_seq: RTL and testbench

//  Operand sequencer/drainer for one N-bit integer MAC PE. Accepts a dot-product request of length
//  len and a valid/ready stream of operand pairs. Drives the PE's load/mult/acc enables in its
//  3-stage order (load -> mult -> acc), then reads back the accumulator and returns it as one

---
 rtl/ast_mac_pkg.sv | 14 +
 rtl/ast_mac_en_pipe.sv | 31 +++
 rtl/ast_mac_seq.sv | 147 ++++++++++++++
 tb/tb_ast_mac_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_mac_pkg.sv
// Shared types for the ast_mac_seq operand sequencer: FSM state encoding and PE pipeline depth.
package ast_mac_pkg;

    localparam int MAC_PIPE_DEPTH = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_e;

endpackage

// File: rtl/ast_mac_en_pipe.sv
// Enable shift register mirroring the PE's load -> mult -> acc stages; empty_o is high when
// no operand pair is still travelling through the PE.
module ast_mac_en_pipe
    import ast_mac_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fire_i,
    output logic [MAC_PIPE_DEPTH-1:0] en_o,
    output logic                      empty_o
);

    logic [MAC_PIPE_DEPTH-1:0] en_q;
    logic [MAC_PIPE_DEPTH-1:0] en_d;

    always_comb begin
        en_d = {en_q[MAC_PIPE_DEPTH-2:0], fire_i};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q <= '0;
        end else begin
            en_q <= en_d;
        end
    end

    assign en_o    = en_q;
    assign empty_o = ~|en_q;

endmodule

// File: rtl/ast_mac_seq.sv
// Operand sequencer/drainer for one MAC PE: clear, feed len pairs, wait for the PE to drain, return the sum.
// Optional stall counter enabled by defining AST_MAC_SEQ_PERF_EN.
module ast_mac_seq
    import ast_mac_pkg::*;
#(
    parameter int DATAWIDTH = 14,
    parameter int LEN_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [DATAWIDTH-1:0]   op_a,
    input  logic [DATAWIDTH-1:0]   op_b,
    output logic [DATAWIDTH-1:0]   mac_a,
    output logic [DATAWIDTH-1:0]   mac_b,
    output logic                   mac_load_en,
    output logic                   mac_mult_en,
    output logic                   mac_acc_en,
    output logic                   mac_clr,
    input  logic [2*DATAWIDTH-1:0] mac_acc,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*DATAWIDTH-1:0] res_data,
    output logic                   busy,
    output logic [15:0]            perf_stall
);

    state_e                    state_q, state_d;
    logic [LEN_W-1:0]          rem_q, rem_d;
    logic [DATAWIDTH-1:0]      a_q, a_d, b_q, b_d;
    logic [2*DATAWIDTH-1:0]    res_q, res_d;
    logic                      clr_q, clr_d;
    logic                      fire;
    logic                      pipe_empty;
    logic [MAC_PIPE_DEPTH-1:0] en;

    assign fire = op_valid && (state_q == FEED);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (rem_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                if (fire) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Only sample the accumulator once no pair is left in flight.
                if (pipe_empty) begin
                    res_d   = mac_acc;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        clr_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            clr_q   <= clr_d;
        end
    end

    ast_mac_en_pipe u_en_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .fire_i  (fire),
        .en_o    (en),
        .empty_o (pipe_empty)
    );

`ifdef AST_MAC_SEQ_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == FEED) && !op_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign perf_stall = stall_q;
`else
    assign perf_stall = 16'h0;
`endif

    assign op_ready    = (state_q == FEED);
    assign res_valid   = (state_q == RESULT);
    assign busy        = (state_q != IDLE);
    assign res_data    = res_q;
    assign mac_a       = a_q;
    assign mac_b       = b_q;
    assign mac_load_en = en[0];
    assign mac_mult_en = en[1];
    assign mac_acc_en  = en[2];
    assign mac_clr     = clr_q;

endmodule

// File: tb/tb_ast_mac_seq.sv
// Bench for ast_mac_seq driving a behavioural 3-stage MAC PE; expectations come from plain dot-product arithmetic.
`timescale 1ns/1ps
module tb_ast_mac_seq;
    localparam int DW = 14;
    localparam int LW = 8;
`ifdef AST_MAC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [LW-1:0]   len = '0;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [DW-1:0]   op_a = '0;
    logic [DW-1:0]   op_b = '0;
    logic [DW-1:0]   mac_a, mac_b;
    logic            mac_load_en, mac_mult_en, mac_acc_en, mac_clr;
    logic [2*DW-1:0] mac_acc;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [2*DW-1:0] res_data;
    logic            busy;
    logic [15:0]     perf_stall;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] ta[16];
    logic [DW-1:0] tbv[16];
    int            tgap[16];

    always #5 clk = ~clk;

    ast_mac_seq #(.DATAWIDTH(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_load_en(mac_load_en),
        .mac_mult_en(mac_mult_en), .mac_acc_en(mac_acc_en), .mac_clr(mac_clr),
        .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .perf_stall(perf_stall)
    );

    // Behavioural MAC PE: load -> multiply -> accumulate, cleared while mac_clr is high.
    logic [DW-1:0]   pe_a, pe_b;
    logic [2*DW-1:0] pe_prod, pe_acc;
    always_ff @(posedge clk or posedge mac_clr) begin
        if (mac_clr) begin
            pe_a <= '0; pe_b <= '0; pe_prod <= '0; pe_acc <= '0;
        end else begin
            if (mac_load_en) begin pe_a <= mac_a; pe_b <= mac_b; end
            if (mac_mult_en) pe_prod <= (2*DW)'(pe_a) * (2*DW)'(pe_b);
            if (mac_acc_en)  pe_acc  <= pe_acc + pe_prod;
        end
    end
    assign mac_acc = pe_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; cycle 0 is the cycle in which start is driven.
    task automatic do_txn(input int n, input int hold, input bit poke_start);
        int hs[16];
        int c, exp_rv, cyc, idx, acc_cnt, load_cnt, extra_rdy, stalls, exp_stall;
        logic [63:0]     sum;
        logic [2*DW-1:0] exp_res;
        sum = 0; c = 2; stalls = 0;
        for (int i = 0; i < n; i++) begin
            hs[i]  = c + tgap[i];
            c      = hs[i] + 1;
            stalls = stalls + tgap[i];
            sum    = sum + 64'(ta[i]) * 64'(tbv[i]);
        end
        exp_res   = sum[2*DW-1:0];
        exp_rv    = (n == 0) ? 3 : hs[n-1] + 5;
        exp_stall = PERF ? stalls : 0;

        start = 1'b1; len = LW'(n);
        tick(); cyc = 1;
        start = 1'b0;
        total++;
        if (mac_clr !== 1'b1) begin bad++; $display("FAIL clr_pulse: got %b expected 1", mac_clr); end
        total++;
        if (perf_stall !== 16'd0) begin bad++; $display("FAIL perf_clear_on_start: got %0d expected 0", perf_stall); end

        idx = 0; acc_cnt = 0; load_cnt = 0; extra_rdy = 0;
        while (res_valid !== 1'b1 && cyc < exp_rv + 10) begin
            if (mac_acc_en === 1'b1) acc_cnt++;
            if (mac_load_en === 1'b1) load_cnt++;
            if (idx < n && cyc == hs[idx]) begin
                op_valid = 1'b1; op_a = ta[idx]; op_b = tbv[idx];
                total++;
                if (op_ready !== 1'b1) begin bad++; $display("FAIL op_ready_at_pair%0d: got %b expected 1 (cycle %0d)", idx, op_ready, cyc); end
                idx++;
            end else begin
                op_valid = 1'b0; op_a = DW'($urandom); op_b = DW'($urandom);
                if (idx >= n && op_ready === 1'b1) extra_rdy++;
            end
            tick(); cyc++;
        end
        op_valid = 1'b0;

        total++;
        if (res_valid !== 1'b1) begin bad++; $display("FAIL res_valid_timeout: got %b expected 1", res_valid); end
        total++;
        if (cyc != exp_rv) begin bad++; $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, exp_rv); end
        total++;
        if (res_data !== exp_res) begin bad++; $display("FAIL res_data: got %0d expected %0d", res_data, exp_res); end
        total++;
        if (acc_cnt != n) begin bad++; $display("FAIL acc_en_cycles: got %0d expected %0d", acc_cnt, n); end
        total++;
        if (load_cnt != n) begin bad++; $display("FAIL load_en_cycles: got %0d expected %0d", load_cnt, n); end
        total++;
        if (extra_rdy != 0) begin bad++; $display("FAIL op_ready_extra: got %0d cycles expected 0", extra_rdy); end
        total++;
        if (perf_stall !== 16'(exp_stall)) begin bad++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall, exp_stall); end

        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            start = poke_start && (h == 1);
            len = LW'(7);
            tick();
            total++;
            if (res_valid !== 1'b1 || res_data !== exp_res) begin
                bad++; $display("FAIL result_hold: got valid=%b data=%0d expected valid=1 data=%0d", res_valid, res_data, exp_res);
            end
        end
        start = 1'b0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL result_release: got valid=%b busy=%b expected 0/0", res_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (op_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got ready=%b valid=%b busy=%b expected 0/0/0", op_ready, res_valid, busy);
        end
        total++;
        if (mac_clr !== 1'b1) begin bad++; $display("FAIL reset_clr: got %b expected 1", mac_clr); end
        total++;
        if (mac_load_en !== 1'b0 || res_data !== '0 || perf_stall !== 16'd0) begin
            bad++; $display("FAIL reset_regs: got load=%b res=%0d perf=%0d expected 0/0/0", mac_load_en, res_data, perf_stall);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (mac_clr !== 1'b0) begin bad++; $display("FAIL clr_release: got %b expected 0", mac_clr); end
    endtask

    task automatic test_basic();
        ta[0] = 2; tbv[0] = 3; tgap[0] = 0;
        ta[1] = 4; tbv[1] = 5; tgap[1] = 0;
        ta[2] = 1; tbv[2] = 7; tgap[2] = 0;
        do_txn(3, 0, 1'b0);
    endtask

    task automatic test_gap();
        ta[0] = 10; tbv[0] = 10; tgap[0] = 0;
        ta[1] = 3;  tbv[1] = 3;  tgap[1] = 2;
        do_txn(2, 0, 1'b0);
    endtask

    task automatic test_len0();
        do_txn(0, 0, 1'b0);
    endtask

    task automatic test_hold();
        ta[0] = DW'($urandom); tbv[0] = DW'($urandom); tgap[0] = 0;
        ta[1] = DW'($urandom); tbv[1] = DW'($urandom); tgap[1] = 1;
        do_txn(2, 5, 1'b1);
    endtask

    task automatic test_mid_reset();
        start = 1'b1; len = LW'(4);
        tick();
        start = 1'b0;
        tick();
        op_valid = 1'b1; op_a = 14'd9; op_b = 14'd9;
        tick();
        op_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || op_ready !== 1'b0 || mac_clr !== 1'b1 || mac_load_en !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got busy=%b ready=%b clr=%b load=%b expected 0/0/1/0", busy, op_ready, mac_clr, mac_load_en);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();
        total++;
        if (mac_clr !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset_release: got clr=%b busy=%b expected 0/0", mac_clr, busy);
        end
        ta[0] = 5; tbv[0] = 5; tgap[0] = 0;
        do_txn(1, 0, 1'b0);
    endtask

    task automatic test_perf();
        ta[0] = 1; tbv[0] = 2; tgap[0] = 1;
        ta[1] = 3; tbv[1] = 4; tgap[1] = 2;
        ta[2] = 5; tbv[2] = 6; tgap[2] = 0;
        do_txn(3, 0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin ta[i] = 14'h3FFF; tbv[i] = 14'h3FFF; tgap[i] = 0; end
        do_txn(4, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                ta[i] = DW'($urandom); tbv[i] = DW'($urandom); tgap[i] = int'($urandom_range(0, 2));
            end
            do_txn(n, int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_len0();
        test_hold();
        test_mid_reset();
        test_perf();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
